// File: rtl/data_mem_slave.sv
// Wait-stated data-memory target for the RV32I load/store bus: byte/half/word lane steering and load extension.
// Optional macro DATA_MEM_ERR_EN enables misalignment, illegal-size and range error reporting.

module data_mem_lane #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;

  assign rdata = mem[idx];
endmodule

module data_mem_slave #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_rd_en_ma,
  input  logic        data_wr_en_ma,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr,
  input  logic [3:0]  data_rd_en_ctrl,
  output logic        data_ready,
  output logic [31:0] data_rd,
  output logic        data_err
);
  localparam int NUM_LANES = 4;
  localparam int IDX_W     = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  ctrl_q;
  logic        rd_q, wr_q;

  // In IDLE the access is decoded from the live bus so zero-wait-state
  // requests can commit on the same edge that accepts them.
  logic        in_idle, req_any, resp_go;
  logic [31:0] addr_s, wdata_s, off;
  logic [2:0]  ctrl_s;
  logic        rd_s, wr_s, both, err, fault;
  logic [1:0]  lane, eff_size;
  logic [IDX_W-1:0] idx;
  logic unused_bits;

  assign in_idle = (state == IDLE);
  assign req_any = data_rd_en_ma | data_wr_en_ma;
  assign addr_s  = in_idle ? data_addr : addr_q;
  assign wdata_s = in_idle ? data_wr : wdata_q;
  assign ctrl_s  = in_idle ? data_rd_en_ctrl[2:0] : ctrl_q;
  assign rd_s    = in_idle ? data_rd_en_ma : rd_q;
  assign wr_s    = in_idle ? data_wr_en_ma : wr_q;
  assign both    = rd_s & wr_s;
  assign off     = addr_s - BASE_ADDR;
  assign idx     = off[IDX_W+1:2];
  assign lane    = addr_s[1:0];
  assign unused_bits = ^{data_rd_en_ctrl[3], off};

`ifdef DATA_MEM_ERR_EN
  logic in_range;
  assign in_range = (off[31:IDX_W+2] == '0);
  assign eff_size = ctrl_s[1:0];
  assign err = both || (ctrl_s[1:0] == 2'b11) || !in_range
            || (ctrl_s[1:0] == 2'b01 && lane[0])
            || (ctrl_s[1:0] == 2'b10 && lane != 2'b00);
`else
  // Illegal size degrades to word; misalignment is absorbed by lane decode.
  assign eff_size = (ctrl_s[1:0] == 2'b11) ? 2'b10 : ctrl_s[1:0];
  assign err      = 1'b0;
`endif
  assign fault = both | err;

  always_comb begin
    resp_go = 1'b0;
    if (in_idle && req_any && WAIT_STATES == 0) resp_go = 1'b1;
    if (state == WAIT && cnt == 4'd1)           resp_go = 1'b1;
  end

  logic [NUM_LANES-1:0][7:0] lane_wdata, lane_rdata;
  logic [NUM_LANES-1:0]      lane_we;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LI = 2'(i);
    logic be;

    always_comb begin
      be            = 1'b0;
      lane_wdata[i] = wdata_s[8*i +: 8];
      case (eff_size)
        2'b00: begin
          be            = (lane == LI);
          lane_wdata[i] = wdata_s[7:0];
        end
        2'b01: begin
          be            = (lane[1] == LI[1]);
          lane_wdata[i] = LI[0] ? wdata_s[15:8] : wdata_s[7:0];
        end
        default: be = 1'b1;
      endcase
    end

    // A reset on the commit edge discards the store.
    assign lane_we[i] = resp_go & wr_s & ~fault & be & ~reset;

    data_mem_lane #(.DEPTH(DEPTH_WORDS), .IDX_W(IDX_W)) u_lane (
      .clk   (clk),
      .we    (lane_we[i]),
      .idx   (idx),
      .wdata (lane_wdata[i]),
      .rdata (lane_rdata[i])
    );
  end

  logic [31:0] rword, load_val;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rword = lane_rdata;
  assign rbyte = rword[{lane, 3'b000} +: 8];
  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    case (eff_size)
      2'b00:   load_val = ctrl_s[2] ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
      2'b01:   load_val = ctrl_s[2] ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
      default: load_val = rword;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      data_ready <= 1'b0;
      data_rd    <= 32'd0;
      data_err   <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      ctrl_q     <= 3'd0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      data_ready <= 1'b0;
      if (resp_go) begin
        data_ready <= 1'b1;
        data_rd    <= (rd_s && !fault) ? load_val : 32'd0;
        data_err   <= err;
      end
      case (state)
        IDLE: if (req_any) begin
          addr_q  <= data_addr;
          wdata_q <= data_wr;
          ctrl_q  <= data_rd_en_ctrl[2:0];
          rd_q    <= data_rd_en_ma;
          wr_q    <= data_wr_en_ma;
          if (WAIT_STATES == 0) state <= RESP;
          else begin
            cnt   <= 4'(WAIT_STATES);
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_slave.sv
// Scoreboard bench for data_mem_slave: directed plan cases plus random traffic against a byte-level model.
// Honours DATA_MEM_ERR_EN the same way the design does.

module tb_data_mem_slave;
  localparam int          DEPTH = 64;
  localparam int          WS    = 2;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0, reset = 1'b1;
  logic        rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  ctrl = '0;
  logic        data_ready, data_err;
  logic [31:0] data_rd;

  always #5 clk = ~clk;

  data_mem_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS), .BASE_ADDR(BASE)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_rd_en_ma   (rd_en),
    .data_wr_en_ma   (wr_en),
    .data_addr       (addr),
    .data_wr         (wdata),
    .data_rd_en_ctrl (ctrl),
    .data_ready      (data_ready),
    .data_rd         (data_rd),
    .data_err        (data_err)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        chk_rd;
    int          cyc;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model [DEPTH];
  int          tests = 0, fails = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every response strobe must match the oldest outstanding expectation.
  exp_t mon_e;
  int   mon_lat;
  always @(negedge clk) begin
    if (data_ready) begin
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL spurious_ready: got data_ready=1 at cycle %0d, want 0", cyc);
      end else begin
        mon_e   = sbq.pop_front();
        mon_lat = cyc - mon_e.cyc;
        if ((mon_e.chk_rd && data_rd !== mon_e.rd) || data_err !== mon_e.err || mon_lat != WS + 1) begin
          fails++;
          $display("FAIL %s: got rd=%h err=%b lat=%0d, want rd=%h err=%b lat=%0d",
                   mon_e.name, data_rd, data_err, mon_lat, mon_e.rd, mon_e.err, WS + 1);
        end
      end
    end
  end

  // Reference: memory as an array of words, access as a run of bytes.
  task automatic model_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic [3:0] c,
                              output logic [31:0] rv, output logic ev);
    int          size, nbytes, first, idx;
    logic [31:0] rel, v, mask;
    logic        inr;
    size = int'(c[1:0]);
    rel  = a - BASE;
    inr  = (a >= BASE) && (longint'(a) < longint'(BASE) + DEPTH * 4);
    idx  = int'((rel >> 2) % DEPTH);
    rv   = 32'd0;
`ifdef DATA_MEM_ERR_EN
    ev = (rd && wr) || size == 3 || (size == 1 && a[0]) || (size == 2 && a[1:0] != 2'b00) || !inr;
`else
    ev = 1'b0;
    if (size == 3) size = 2;
`endif
    if ((rd && wr) || ev) return;
    nbytes = 1 << size;
    first  = int'(a[1:0]) / nbytes * nbytes;
    if (wr) begin
      for (int b = 0; b < nbytes; b++) model[idx][8*(first+b) +: 8] = wd[8*b +: 8];
    end else if (nbytes == 4) begin
      rv = model[idx];
    end else begin
      mask = (32'h1 << (8 * nbytes)) - 32'h1;
      v    = (model[idx] >> (8 * first)) & mask;
      if (!c[2] && v[8*nbytes-1]) v = v | ~mask;
      rv = v;
    end
  endtask

  task automatic do_req(input string name, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] c);
    logic [31:0] rv;
    logic        ev;
    exp_t        e;
    bit          seen;
    @(negedge clk);
    model_access(rd, wr, a, wd, c, rv, ev);
    e.rd = rv; e.err = ev; e.chk_rd = rd; e.cyc = cyc; e.name = name;
    sbq.push_back(e);
    rd_en = rd; wr_en = wr; addr = a; wdata = wd; ctrl = c;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = data_ready;
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL %s_timeout: got no data_ready in 40 cycles, want one after %0d", name, WS + 1);
    end
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  initial begin
    logic [31:0] ra;
    int          r;
    repeat (3) @(negedge clk);
    check("reset_ready", {31'd0, data_ready}, 32'd0);
    check("reset_rd", data_rd, 32'd0);
    check("reset_err", {31'd0, data_err}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) do_req("prefill", 1'b0, 1'b1, BASE + 32'(i * 4), $urandom, 4'b0010);

    do_req("st_deadbeef", 1'b0, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'b0010);
    do_req("ld_deadbeef", 1'b1, 1'b0, BASE + 32'h10, 32'h0, 4'b0010);
    do_req("st_11223344", 1'b0, 1'b1, BASE + 32'h10, 32'h1122_3344, 4'b0010);
    do_req("st_byte80", 1'b0, 1'b1, BASE + 32'h13, 32'h0000_0080, 4'b0000);
    do_req("ld_byte_s", 1'b1, 1'b0, BASE + 32'h13, 32'h0, 4'b0000);
    do_req("ld_byte_u", 1'b1, 1'b0, BASE + 32'h13, 32'h0, 4'b0100);
    do_req("ld_word_merge", 1'b1, 1'b0, BASE + 32'h10, 32'h0, 4'b0010);
    do_req("ld_half_s", 1'b1, 1'b0, BASE + 32'h12, 32'h0, 4'b0001);
    do_req("ld_half_mis", 1'b1, 1'b0, BASE + 32'h11, 32'h0, 4'b0001);
    do_req("rdwr_both", 1'b1, 1'b1, BASE + 32'h20, 32'h5555_5555, 4'b0010);
    do_req("ld_after_both", 1'b1, 1'b0, BASE + 32'h20, 32'h0, 4'b0010);
    do_req("ld_top_oob", 1'b1, 1'b0, BASE + 32'(DEPTH * 4), 32'h0, 4'b0010);
    do_req("ld_below_base", 1'b1, 1'b0, BASE - 32'h4, 32'h0, 4'b0010);
    do_req("ld_size11", 1'b1, 1'b0, BASE + 32'h14, 32'h0, 4'b0011);
    do_req("ld_ctrl3", 1'b1, 1'b0, BASE + 32'h13, 32'h0, 4'b1000);

    // Store aborted by reset while waiting must not commit or respond.
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b1; addr = BASE + 32'h30; wdata = 32'hA5A5_A5A5; ctrl = 4'b0010;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; wr_en = 1'b0;
    check("abort_ready", {31'd0, data_ready}, 32'd0);
    check("abort_rd", data_rd, 32'd0);
    repeat (5) @(negedge clk);
    do_req("ld_after_abort", 1'b1, 1'b0, BASE + 32'h30, 32'h0, 4'b0010);

    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 15));
      case ($urandom_range(0, 7))
        0:       ra = BASE + 32'(DEPTH * 4) + $urandom_range(0, 255);
        1:       ra = BASE - 32'd1 - $urandom_range(0, 255);
        default: ra = BASE + $urandom_range(0, DEPTH * 4 - 1);
      endcase
      do_req("random", (r == 0) || (r >= 8), (r < 8), ra, $urandom, 4'($urandom_range(0, 15)));
    end

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
